// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/external RAM arbiter.
// Command encodings, the owner enum used for last winner and read tags, and default widths.
package mem_arb_pkg;

   localparam int AW_DEF = 9;
   localparam int DW_DEF = 16;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CPU  = 2'd1,
      EXT  = 2'd2
   } owner_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational round-robin pick between CPU (bit 0) and external port (bit 1).
// The output win is one-hot or zero; force_ext overrides the rotation on contention.
module arb_rr_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     last_win,
   input  logic       force_ext,
   output logic [1:0] win
);

   // A lone requester always wins; on contention the side that did not win last goes.
   always_comb begin
      win = 2'b00;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = (force_ext || last_win == CPU) ? 2'b10 : 2'b01;
         default: win = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one 512x16 synchronous RAM between the CPU port and an external port.
// Optional grant counters are enabled with the MEM_ARB_STATS_EN macro.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    cpu_cmd,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_stall,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rvalid,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic          ext_gnt,
   output logic [DW-1:0] ext_rdata,
   output logic          ext_rvalid,
   output logic [AW-1:0] ram_addr,
   output logic          ram_write,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0]   cpu_grants,
   output logic [15:0]   ext_grants
`endif
);

   localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   owner_t        last_win_q, last_win_d;
   owner_t        rd_tag_q, rd_tag_d;
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;

   logic       cpu_req, cpu_is_wr, force_ext;
   logic [1:0] req, win;

   assign cpu_req   = (cpu_cmd == MREAD) || (cpu_cmd == MWRITE);
   assign cpu_is_wr = (cpu_cmd == MWRITE);
   assign force_ext = (wait_cnt_q == WW'(MAX_WAIT));
   // Requests are masked during reset so nothing reaches the RAM or the grant state.
   assign req       = {ext_req, cpu_req} & {2{reset}};

   arb_rr_pick u_pick (
      .req       (req),
      .last_win  (last_win_q),
      .force_ext (force_ext),
      .win       (win)
   );

   always_comb begin
      ram_addr  = '0;
      ram_din   = '0;
      ram_write = 1'b0;
      if (win[0]) begin
         ram_addr  = cpu_addr;
         ram_din   = cpu_wdata;
         ram_write = cpu_is_wr;
      end else if (win[1]) begin
         ram_addr  = ext_addr;
         ram_din   = ext_wdata;
         ram_write = ext_we;
      end
   end

   assign cpu_stall  = cpu_req & ~win[0];
   assign ext_gnt    = ext_req & win[1];
   assign cpu_rdata  = ram_dout;
   assign ext_rdata  = ram_dout;
   assign cpu_rvalid = (rd_tag_q == CPU);
   assign ext_rvalid = (rd_tag_q == EXT);

   always_comb begin
      last_win_d = last_win_q;
      rd_tag_d   = NONE;
      wait_cnt_d = wait_cnt_q;
      if (win[0]) begin
         last_win_d = CPU;
         if (!cpu_is_wr) rd_tag_d = CPU;
      end else if (win[1]) begin
         last_win_d = EXT;
         if (!ext_we) rd_tag_d = EXT;
      end
      if (!ext_req || ext_gnt) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WW'(MAX_WAIT)) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_win_q <= EXT;
         rd_tag_q   <= NONE;
         wait_cnt_q <= '0;
      end else begin
         last_win_q <= last_win_d;
         rd_tag_q   <= rd_tag_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [15:0] cpu_grants_q, cpu_grants_d;
   logic [15:0] ext_grants_q, ext_grants_d;

   // Free-running wrap-around counters of granted accesses per port.
   always_comb begin
      cpu_grants_d = cpu_grants_q + {15'd0, win[0]};
      ext_grants_d = ext_grants_q + {15'd0, win[1]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_grants_q <= '0;
         ext_grants_q <= '0;
      end else begin
         cpu_grants_q <= cpu_grants_d;
         ext_grants_q <= ext_grants_d;
      end
   end

   assign cpu_grants = cpu_grants_q;
   assign ext_grants = ext_grants_q;
`endif

endmodule
